rx_byte_buffer: RTL and testbench
=================================

// Module: rx_byte_buffer
// PURPOSE
// - Byte-granular circular receive buffer directly downstream of the generation/lane decoder.
// - Accepts one beat per cycle of up to 64 bytes, qualified by a write strobe and a contiguous byte-valid mask.
// - Repacks the stream into fixed RD_BYTES words for the data link layer using a valid/ready handshake.
// - Empties and holds itself while the link is down.
// PARAMETERS
// - DEPTH_BYTES  256  storage size in bytes; power of two, >= 64 + RD_BYTES
// - RD_BYTES     8    bytes per output word; power of two, 1..32
// - PTR_W        $clog2(DEPTH_BYTES)  pointer width; derived, do not override
// PORTS
// - clk        in   1          single clock; all logic on rising edge
// - reset      in   1          synchronous, active-high reset
// - linkup     in   1          link trained; 0 forces DOWN state
// - w          in   1          write strobe for current beat
// - valid      in   64         byte-valid mask; bit i qualifies data_in[8*i+7:8*i]
// - data_in    in   512        beat data; byte 0 = bits [7:0]
// - rd_data    out  RD_BYTES*8 output word; oldest byte in bits [7:0]
// - rd_valid   out  1          rd_data holds RD_BYTES valid bytes
// - rd_ready   in   1          consumer accepts word when rd_valid & rd_ready
// - overflow   out  1          sticky: a beat was dropped for lack of space
// BEHAVIOUR
// - Reset: wr_ptr = rd_ptr = occ = 0; overflow = 0; rd_valid = 0; state = DOWN. rd_data is don't-care.
// - FSM DOWN: writes ignored, occ/pointers held at 0, rd_valid = 0. Go to UP on the cycle after linkup = 1.
// - FSM UP: normal operation. linkup = 0 -> DOWN next cycle, discarding contents. overflow is NOT cleared.
// - Beat byte count wcnt = number of contiguous 1s in valid starting at bit 0 (0..64).
//   Bits above the first 0 are ignored. valid = 0 means no write.
// - Write accepted when state = UP, w = 1, wcnt > 0 and wcnt <= DEPTH_BYTES - occ.
//   occ here is the registered value; a same-cycle read does not add free space.
// - Rejected beat (wcnt exceeds free space): the whole beat is dropped, nothing partial is written,
//   and overflow sets on the next edge. overflow clears only on reset.
// - Accepted beat: byte k goes to mem[(wr_ptr + k) mod DEPTH_BYTES] for k < wcnt; wr_ptr += wcnt modulo DEPTH_BYTES.
// - rd_valid = (state == UP) && (occ >= RD_BYTES), combinational from registered occ.
// - rd_data byte j = mem[(rd_ptr + j) mod DEPTH_BYTES]; it is stable while rd_valid & !rd_ready.
// - Pop on rd_valid & rd_ready: rd_ptr += RD_BYTES modulo DEPTH_BYTES.
// - occ_next = occ + (accepted ? wcnt : 0) - (pop ? RD_BYTES : 0); occ is PTR_W+1 bits wide.
// - Latency: a beat accepted at edge N can show rd_valid from cycle N+1.
// - Fewer than RD_BYTES bytes resident: they wait for more data; no partial words are ever emitted.
// - Wrap-around: writes and reads crossing address DEPTH_BYTES-1 continue at 0 without a gap.
// - Simultaneous accept and pop in one cycle is legal; occ is updated with both.
// - reset or linkup loss mid-word discards any partially accumulated bytes.
// CONFIGURATION
// - Macro RX_BYTE_BUFFER_STATUS_EN.
// - Defined: adds output occupancy [PTR_W:0], equal to registered occ (0 at reset and in DOWN).
// - Defined: adds output high_water [PTR_W:0], the max occ seen since reset. It is held through DOWN
//   and reset to 0 only by reset.
// - Undefined: neither port exists and no high-water logic is built; all other behaviour is identical.
// TESTING
// - Reset, then linkup=1, w=1, valid=64'hFF, data bytes 0x00..0x07
//   -> next cycle rd_valid=1, rd_data=64'h0706050403020100.
// - Three beats of 3 bytes each (valid=64'h7) with rd_ready=1
//   -> one word after beat 3 (bytes 0..7), 1 byte left, rd_valid=0.
// - Fill to occ=250 (DEPTH 256) with rd_ready=0, then a beat with valid=64'hFF
//   -> beat dropped, overflow=1 sticky, occ stays 250.
// - valid=64'h0F0F with w=1 -> only 4 bytes written (wcnt=4).
// - Pointers near 252, then a 16-byte write and reads
//   -> bytes emerge in order across the wrap.
// - linkup drops with occ=40
//   -> next cycle rd_valid=0 and occ=0; after linkup returns, first data out is from new beats only.

Source files
------------

// File: rtl/rx_byte_buffer.sv
// rx_byte_buffer: byte-granular circular receive buffer.
// Accepts beats of up to 64 bytes, qualified by a contiguous byte-valid mask,
// and repacks them into RD_BYTES-wide words behind a valid/ready handshake.
// While the link is down the buffer empties itself and holds.
// Optional status outputs (occupancy, high_water) are built only when the
// macro RX_BYTE_BUFFER_STATUS_EN is defined.
module rx_byte_buffer #(
  parameter int DEPTH_BYTES = 256,
  parameter int RD_BYTES    = 8,
  parameter int PTR_W       = $clog2(DEPTH_BYTES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  linkup,
  input  logic                  w,
  input  logic [63:0]           valid,
  input  logic [511:0]          data_in,
  output logic [RD_BYTES*8-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  overflow
`ifdef RX_BYTE_BUFFER_STATUS_EN
  ,
  output logic [PTR_W:0]        occupancy,
  output logic [PTR_W:0]        high_water
`endif
);

  localparam logic [0:0] S_DOWN = 1'b0;
  localparam logic [0:0] S_UP   = 1'b1;

  logic [0:0]       state;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   occ;
  logic [PTR_W:0]   occ_next;
  logic [PTR_W:0]   free_bytes;
  logic [PTR_W:0]   wcnt_ext;
  logic [6:0]       wcnt;
  logic             wr_req;
  logic             accept;
  logic             reject;
  logic             pop;

  logic [7:0] mem [DEPTH_BYTES];

  // Length of the run of 1s starting at bit 0; anything above the first 0 is ignored.
  function automatic logic [6:0] lead_ones(input logic [63:0] m);
    logic [6:0] n;
    n = 7'd64;
    for (int i = 63; i >= 0; i--) begin
      if (!m[i]) n = 7'(i);
    end
    return n;
  endfunction

  // Beat sizing, space check against registered occupancy, and read handshake.
  always_comb begin
    wcnt       = lead_ones(valid);
    wcnt_ext   = (PTR_W+1)'(wcnt);
    free_bytes = (PTR_W+1)'(DEPTH_BYTES) - occ;
    wr_req     = (state == S_UP) && w && (wcnt != 7'd0);
    accept     = wr_req && (wcnt_ext <= free_bytes);
    reject     = wr_req && (wcnt_ext > free_bytes);
    rd_valid   = (state == S_UP) && (occ >= (PTR_W+1)'(RD_BYTES));
    pop        = rd_valid && rd_ready;
    occ_next   = occ + (accept ? wcnt_ext : '0)
                     - (pop ? (PTR_W+1)'(RD_BYTES) : '0);
  end

  // Link state, pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_DOWN;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      overflow <= 1'b0;
    end else begin
      if (reject) overflow <= 1'b1;
      case (state)
        S_DOWN: begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          occ    <= '0;
          if (linkup) state <= S_UP;
        end
        default: begin
          if (!linkup) begin
            state  <= S_DOWN;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
          end else begin
            wr_ptr <= wr_ptr + (accept ? PTR_W'(wcnt) : '0);
            rd_ptr <= rd_ptr + (pop ? PTR_W'(RD_BYTES) : '0);
            occ    <= occ_next;
          end
        end
      endcase
    end
  end

  // Byte storage: an accepted beat lands at consecutive addresses from wr_ptr, wrapping.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 64; k++) begin
      if (accept && (7'(k) < wcnt)) begin
        mem[wr_ptr + PTR_W'(k)] <= data_in[8*k +: 8];
      end
    end
  end

  // Output word: the RD_BYTES oldest bytes, oldest in the low byte lane.
  always_comb begin
    rd_data = '0;
    for (int j = 0; j < RD_BYTES; j++) begin
      rd_data[8*j +: 8] = mem[rd_ptr + PTR_W'(j)];
    end
  end

`ifdef RX_BYTE_BUFFER_STATUS_EN
  assign occupancy = occ;

  // Peak occupancy since reset; survives link-down periods.
  always_ff @(posedge clk) begin
    if (reset) begin
      high_water <= '0;
    end else if (occ_next > high_water) begin
      high_water <= occ_next;
    end
  end
`endif

endmodule

// File: tb/tb_rx_byte_buffer.sv
// Testbench for rx_byte_buffer: directed scenarios followed by randomized
// traffic, all compared against a byte-queue reference model.
module tb_rx_byte_buffer;

  localparam int DEPTH = 256;
  localparam int RDB   = 8;
  localparam int PW    = $clog2(DEPTH);

  logic         clk = 1'b0;
  logic         reset;
  logic         linkup;
  logic         w;
  logic [63:0]  valid;
  logic [511:0] data_in;
  logic [63:0]  rd_data;
  logic         rd_valid;
  logic         rd_ready;
  logic         overflow;
`ifdef RX_BYTE_BUFFER_STATUS_EN
  logic [PW:0]  occupancy;
  logic [PW:0]  high_water;
`endif

  rx_byte_buffer #(.DEPTH_BYTES(DEPTH), .RD_BYTES(RDB)) dut (
    .clk(clk),
    .reset(reset),
    .linkup(linkup),
    .w(w),
    .valid(valid),
    .data_in(data_in),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .overflow(overflow)
`ifdef RX_BYTE_BUFFER_STATUS_EN
    ,
    .occupancy(occupancy),
    .high_water(high_water)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: resident bytes in arrival order, link state, sticky flag.
  byte unsigned q[$];
  bit           m_up;
  bit           m_ovf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [63:0] mask_of(input int n);
    if (n >= 64) return '1;
    return (64'd1 << n) - 64'd1;
  endfunction

  function automatic logic [511:0] seq_data(input int start);
    logic [511:0] d;
    for (int k = 0; k < 64; k++) d[8*k +: 8] = 8'(start + k);
    return d;
  endfunction

  function automatic logic [511:0] rand_data();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  // One clock: drive inputs, compare outputs mid-cycle, advance the model at the edge.
  task automatic cycle(input bit rs, input bit lk, input bit wr, input logic [63:0] vm,
                       input logic [511:0] d, input bit rr);
    bit          exp_vld;
    logic [63:0] ew;
    int          n;
    int          sz0;
    reset = rs; linkup = lk; w = wr; valid = vm; data_in = d; rd_ready = rr;
    #4;
    exp_vld = m_up && (q.size() >= RDB);
    check("rd_valid", 64'(rd_valid), 64'(exp_vld));
    if (exp_vld) begin
      for (int j = 0; j < RDB; j++) ew[8*j +: 8] = q[j];
      check("rd_data", rd_data, ew);
    end
    check("overflow", 64'(overflow), 64'(m_ovf));
    if (rs) begin
      q.delete(); m_up = 0; m_ovf = 0;
    end else if (!m_up) begin
      if (lk) m_up = 1;
    end else if (!lk) begin
      q.delete(); m_up = 0;
    end else begin
      n = 0;
      while (n < 64 && vm[n]) n++;
      sz0 = q.size();
      if (exp_vld && rr) for (int j = 0; j < RDB; j++) void'(q.pop_front());
      if (wr && n > 0) begin
        if (n <= DEPTH - sz0) for (int k = 0; k < n; k++) q.push_back(d[8*k +: 8]);
        else m_ovf = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          n;
    bit          lk;
    logic [63:0] vm;
    m_up = 0; m_ovf = 0;
    reset = 1; linkup = 0; w = 0; valid = '0; data_in = '0; rd_ready = 0;
    @(posedge clk); #1;
    cycle(1, 0, 0, '0, '0, 0);
    cycle(0, 0, 0, '0, '0, 0);
    check("reset_vld", 64'(rd_valid), 64'd0);
    check("reset_ovf", 64'(overflow), 64'd0);

    // First 8-byte beat appears as a word on the next cycle.
    cycle(0, 1, 0, '0, '0, 0);
    cycle(0, 1, 1, 64'hFF, seq_data(0), 0);
    check("first_vld", 64'(rd_valid), 64'd1);
    check("first_word", rd_data, 64'h0706050403020100);
    cycle(0, 1, 0, '0, '0, 1);

    // Three 3-byte beats: one word, one byte left over.
    cycle(0, 1, 1, 64'h7, seq_data(8), 1);
    cycle(0, 1, 1, 64'h7, seq_data(11), 1);
    cycle(0, 1, 1, 64'h7, seq_data(14), 1);
    check("pack_vld", 64'(rd_valid), 64'd1);
    check("pack_word", rd_data, 64'h0F0E0D0C0B0A0908);
    cycle(0, 1, 0, '0, '0, 1);
    check("pack_left", 64'(rd_valid), 64'd0);

    // Fill to 250 bytes, then an 8-byte beat must be dropped whole.
    while (q.size() < 250) begin
      n = 250 - q.size();
      if (n > 64) n = 64;
      cycle(0, 1, 1, mask_of(n), rand_data(), 0);
    end
    cycle(0, 1, 1, 64'hFF, seq_data(200), 0);
    check("ovf_set", 64'(overflow), 64'd1);
    for (int i = 0; i < 32; i++) cycle(0, 1, 0, '0, '0, 1);
    check("drain_left", 64'(rd_valid), 64'd0);
    check("ovf_sticky", 64'(overflow), 64'd1);

    // Non-contiguous mask writes only the leading run.
    cycle(0, 1, 1, 64'h0F0F, seq_data(8'h40), 0);
    check("mask_vld0", 64'(rd_valid), 64'd0);
    cycle(0, 1, 1, 64'h3, seq_data(8'h44), 0);
    check("mask_vld1", 64'(rd_valid), 64'd1);
    cycle(0, 1, 0, '0, '0, 1);

    // Link loss with 40 resident bytes; only new data after recovery.
    cycle(0, 1, 1, mask_of(40), rand_data(), 0);
    cycle(0, 0, 0, '0, '0, 0);
    check("down_vld", 64'(rd_valid), 64'd0);
    cycle(0, 0, 0, '0, '0, 1);
    cycle(0, 1, 0, '0, '0, 1);
    cycle(0, 1, 1, 64'hFF, seq_data(8'hA0), 0);
    check("relink_word", rd_data, 64'hA7A6A5A4A3A2A1A0);
    check("relink_ovf", 64'(overflow), 64'd1);
    cycle(0, 1, 0, '0, '0, 1);

    // Move pointers near the top of memory, then write across the wrap.
    while (q.size() < 244) begin
      n = 244 - q.size();
      if (n > 64) n = 64;
      cycle(0, 1, 1, mask_of(n), rand_data(), 0);
    end
    while (q.size() >= RDB) cycle(0, 1, 0, '0, '0, 1);
    cycle(0, 1, 1, mask_of(16), seq_data(8'hC0), 1);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, '0, '0, 1);

    // Randomized traffic.
    lk = 1;
    for (int i = 0; i < 3000; i++) begin
      if (lk) lk = ($urandom_range(0, 63) != 0);
      else    lk = ($urandom_range(0, 3) == 0);
      n  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 64)) : int'($urandom_range(0, 12));
      vm = mask_of(n);
      if (n < 63) vm = vm | ({$urandom, $urandom} << (n + 1));
      cycle(($urandom_range(0, 499) == 0), lk, lk && ($urandom_range(0, 1) == 1), vm,
            rand_data(), ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
